// File: rtl/npu_spi_master.sv
// SPI mode-0 master that ships one 32-bit command frame to the NPU per host request.
// For start-compute commands it then waits, up to a bounded time, for npu_done.
`timescale 1ns/1ps
module npu_spi_master #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_cmd,
    input  logic [2:0] req_tile_i,
    input  logic [2:0] req_tile_j,
    input  logic [2:0] req_op,
    input  logic [7:0] req_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_timeout,
    output logic       busy,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    input  logic       miso,
    input  logic       npu_done
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [7:0] CmdStart = 8'h02;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StWaitDone,
        StResp
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       frame_q, frame_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [5:0]        bit_cnt_q, bit_cnt_d;
    logic [DivW-1:0]   div_cnt_q, div_cnt_d;
    logic [31:0]       cnt_q, cnt_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic [7:0]        rx_q, rx_d;
    logic              timeout_q, timeout_d;
    logic              ready_q;

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        cmd_d     = cmd_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        cnt_d     = cnt_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        rx_d      = rx_q;
        timeout_d = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready) begin
                    state_d   = StSetup;
                    frame_d   = {req_cmd, 2'b00, req_tile_i, req_tile_j, 5'b00000, req_op,
                                 req_data};
                    cmd_d     = req_cmd;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    cnt_d     = '0;
                    cs_n_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            StSetup: begin
                if (cnt_q == 32'(CS_SETUP - 1)) begin
                    // First rising edge: sample miso on the edge that raises sclk.
                    state_d   = StShift;
                    sclk_d    = 1'b1;
                    div_cnt_d = '0;
                    rx_d      = {rx_q[6:0], miso};
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StShift: begin
                if (div_cnt_q == DivLast) begin
                    div_cnt_d = '0;
                    if (sclk_q) begin
                        sclk_d    = 1'b0;
                        frame_d   = {frame_q[30:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 6'd1;
                    end else if (bit_cnt_q == 6'd32) begin
                        state_d = StHold;
                        cnt_d   = '0;
                    end else begin
                        sclk_d = 1'b1;
                        rx_d   = {rx_q[6:0], miso};
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DivW'(1);
                end
            end
            StHold: begin
                if (cnt_q == 32'(CS_HOLD - 1)) begin
                    cs_n_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = (cmd_q == CmdStart) ? StWaitDone : StResp;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitDone: begin
                // A done seen in the terminal-count cycle takes priority over timeout.
                if (npu_done) begin
                    state_d   = StResp;
                    timeout_d = 1'b0;
                end else if (cnt_q == 32'(TIMEOUT - 1)) begin
                    state_d   = StResp;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            frame_q   <= '0;
            cmd_q     <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            cnt_q     <= '0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            rx_q      <= '0;
            timeout_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            cmd_q     <= cmd_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            cnt_q     <= cnt_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            rx_q      <= rx_d;
            timeout_q <= timeout_d;
            ready_q   <= 1'b1;
        end
    end

    // ready_q keeps req_ready low during reset and for the reset-release edge.
    assign req_ready   = ready_q && (state_q == StIdle);
    assign busy        = (state_q != StIdle);
    assign rsp_valid   = (state_q == StResp);
    assign rsp_timeout = rsp_valid && timeout_q;
    assign rsp_data    = rx_q;
    assign sclk        = sclk_q;
    assign cs_n        = cs_n_q;
    assign mosi        = frame_q[31] & ~cs_n_q;

endmodule

// File: tb/tb_npu_spi_master.sv
// Randomized self-checking bench for npu_spi_master against a frame-level reference model.
`timescale 1ns/1ps
module tb_npu_spi_master;

    localparam int CLK_DIV  = 4;
    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int TIMEOUT  = 1024;
    localparam int CS_LOW   = CS_SETUP + 2 * 32 * CLK_DIV + CS_HOLD;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [7:0] req_cmd = '0;
    logic [2:0] req_tile_i = '0;
    logic [2:0] req_tile_j = '0;
    logic [2:0] req_op = '0;
    logic [7:0] req_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_timeout;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso = 1'b0;
    logic       npu_done = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    // Results of the most recent observed frame.
    logic [31:0] r_mosi;
    int          r_cs_low;
    int          r_rises;
    int          r_rsp_at;
    logic [7:0]  r_rsp_data;
    logic        r_rsp_to;
    int          r_inv;

    npu_spi_master #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_HOLD (CS_HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_cmd    (req_cmd),
        .req_tile_i (req_tile_i),
        .req_tile_j (req_tile_j),
        .req_op     (req_op),
        .req_data   (req_data),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_timeout(rsp_timeout),
        .busy       (busy),
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .miso       (miso),
        .npu_done   (npu_done)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] model_frame(input logic [7:0] cmd, input logic [2:0] ti,
                                                input logic [2:0] tj, input logic [2:0] op,
                                                input logic [7:0] data);
        return {cmd, 2'b00, ti, tj, 5'b00000, op, data};
    endfunction

    // Presents one request and returns at the sample just after the accepting edge.
    task automatic send_req(input logic [7:0] cmd, input logic [2:0] ti, input logic [2:0] tj,
                            input logic [2:0] op, input logic [7:0] data);
        int w = 0;
        while (!req_ready && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        req_valid  = 1'b1;
        req_cmd    = cmd;
        req_tile_i = ti;
        req_tile_j = tj;
        req_op     = op;
        req_data   = data;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        // Scramble the fields so only latched values can reach the wire.
        req_cmd    = 8'($urandom);
        req_tile_i = 3'($urandom);
        req_tile_j = 3'($urandom);
        req_op     = 3'($urandom);
        req_data   = 8'($urandom);
    endtask

    // Plays the NPU side of one frame: miso from {FF,FF,FF,b3}, optional npu_done pulse
    // done_delay cycles after cs_n rises (negative = never). Stops at rsp_valid.
    task automatic observe_frame(input logic [7:0] b3, input int done_delay);
        logic [31:0] mw;
        logic        prev_sclk, prev_mosi;
        int          idx, since;
        mw = {24'hFFFFFF, b3};
        prev_sclk = 1'b0;
        prev_mosi = mosi;
        idx = 0;
        since = -1;
        r_mosi = '0; r_cs_low = 0; r_rises = 0; r_rsp_at = -1;
        r_rsp_data = '0; r_rsp_to = 1'b0; r_inv = 0;
        miso = mw[31];
        for (int c = 0; c < 4000; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (npu_done) npu_done = 1'b0;
            if (!cs_n) r_cs_low++;
            if (sclk && !prev_sclk) begin
                r_rises++;
                r_mosi = {r_mosi[30:0], mosi};
            end
            if (!sclk && prev_sclk) begin
                idx++;
                miso = (idx < 32) ? mw[31 - idx] : 1'b0;
            end
            if (sclk && prev_sclk && (mosi !== prev_mosi)) r_inv++;
            if (cs_n && (sclk || mosi)) r_inv++;
            if (!rsp_valid && rsp_timeout) r_inv++;
            if (busy === req_ready) r_inv++;
            if (since >= 0) since++;
            else if (cs_n) since = 0;
            if (rsp_valid) begin
                r_rsp_at   = since;
                r_rsp_data = rsp_data;
                r_rsp_to   = rsp_timeout;
                break;
            end
            if (since >= 0 && since == done_delay) npu_done = 1'b1;
            prev_sclk = sclk;
            prev_mosi = mosi;
        end
        miso = 1'b0;
    endtask

    // One full transaction checked against the frame-level model.
    task automatic frame_scenario(input string tag, input logic [7:0] cmd, input logic [2:0] ti,
                                  input logic [2:0] tj, input logic [2:0] op,
                                  input logic [7:0] data, input logic [7:0] b3,
                                  input int done_delay);
        logic [31:0] exp_word;
        int          exp_at;
        logic        exp_to;
        exp_word = model_frame(cmd, ti, tj, op, data);
        if (cmd != 8'h02) begin
            exp_at = 0;
            exp_to = 1'b0;
        end else if (done_delay >= 0 && done_delay < TIMEOUT) begin
            exp_at = done_delay + 1;
            exp_to = 1'b0;
        end else begin
            exp_at = TIMEOUT;
            exp_to = 1'b1;
        end
        send_req(cmd, ti, tj, op, data);
        n_checks++;
        if (cs_n !== 1'b0 || mosi !== exp_word[31]) begin
            n_fail++;
            $display("FAIL %s accept: cs_n=%b mosi=%b want cs_n=0 mosi=%b", tag, cs_n, mosi,
                     exp_word[31]);
        end
        observe_frame(b3, done_delay);
        n_checks++;
        if (r_mosi !== exp_word) begin
            n_fail++;
            $display("FAIL %s mosi_word: got %h want %h", tag, r_mosi, exp_word);
        end
        n_checks++;
        if (r_rises !== 32) begin
            n_fail++;
            $display("FAIL %s sclk_rises: got %0d want 32", tag, r_rises);
        end
        n_checks++;
        if (r_cs_low !== CS_LOW) begin
            n_fail++;
            $display("FAIL %s cs_low: got %0d want %0d", tag, r_cs_low, CS_LOW);
        end
        n_checks++;
        if (r_rsp_at !== exp_at || r_rsp_to !== exp_to) begin
            n_fail++;
            $display("FAIL %s rsp_timing: at %0d to %b want at %0d to %b", tag, r_rsp_at,
                     r_rsp_to, exp_at, exp_to);
        end
        n_checks++;
        if (r_rsp_data !== b3) begin
            n_fail++;
            $display("FAIL %s rsp_data: got %h want %h", tag, r_rsp_data, b3);
        end
        n_checks++;
        if (r_inv !== 0) begin
            n_fail++;
            $display("FAIL %s invariants: %0d violations want 0", tag, r_inv);
        end
        @(posedge clk); #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || busy !== 1'b0 ||
            req_ready !== 1'b1 || rsp_data !== b3) begin
            n_fail++;
            $display("FAIL %s after_rsp: valid=%b to=%b busy=%b ready=%b data=%h want 0 0 0 1 %h",
                     tag, rsp_valid, rsp_timeout, busy, req_ready, rsp_data, b3);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || req_ready !== 1'b0 ||
            busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_timeout !== 1'b0 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs: cs_n=%b sclk=%b mosi=%b ready=%b busy=%b valid=%b to=%b data=%h",
                     cs_n, sclk, mosi, req_ready, busy, rsp_valid, rsp_timeout, rsp_data);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: ready=%b busy=%b want 1 0", req_ready, busy);
        end
    endtask

    task automatic test_write_frame();
        frame_scenario("write_directed", 8'h01, 3'd5, 3'd2, 3'd0, 8'hA5, 8'h3C, -1);
        for (int k = 0; k < 3; k++) begin
            logic [7:0] cmd;
            cmd = 8'($urandom);
            if (cmd == 8'h02) cmd = 8'h01;
            frame_scenario("write_random", cmd, 3'($urandom), 3'($urandom), 3'($urandom),
                           8'($urandom), 8'($urandom), -1);
        end
    endtask

    task automatic test_compute_done();
        frame_scenario("compute_done50", 8'h02, 3'd1, 3'd7, 3'd4, 8'h5A, 8'h81, 50);
        frame_scenario("compute_done_rand", 8'h02, 3'($urandom), 3'($urandom), 3'($urandom),
                       8'($urandom), 8'($urandom), int'($urandom_range(0, 300)));
        frame_scenario("compute_done_terminal", 8'h02, 3'd2, 3'd3, 3'd5, 8'h00, 8'hC3,
                       TIMEOUT - 1);
    endtask

    task automatic test_compute_timeout();
        frame_scenario("compute_timeout", 8'h02, 3'd0, 3'd0, 3'd7, 8'hFF, 8'h11, -1);
    endtask

    task automatic test_reset_mid_frame();
        logic prev_sclk;
        int   rises, bad;
        send_req(8'h01, 3'($urandom), 3'($urandom), 3'($urandom), 8'($urandom));
        prev_sclk = 1'b0;
        rises = 0;
        // Run until frame bit 10 is on the wire (22nd rising edge, counting down from 31).
        for (int c = 0; c < 400 && rises < 22; c++) begin
            @(posedge clk); #1;
            if (sclk && !prev_sclk) rises++;
            prev_sclk = sclk;
        end
        n_checks++;
        if (rises !== 22) begin
            n_fail++;
            $display("FAIL midreset_reach: rises %0d want 22", rises);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0 || rsp_valid !== 1'b0 ||
            busy !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 8'h00) begin
            n_fail++;
            $display("FAIL midreset_async: cs_n=%b sclk=%b mosi=%b valid=%b busy=%b ready=%b data=%h",
                     cs_n, sclk, mosi, rsp_valid, busy, req_ready, rsp_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_ready: got %b want 1", req_ready);
        end
        bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || !cs_n || busy || sclk) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: %0d active cycles want 0", bad);
        end
        frame_scenario("after_midreset", 8'h01, 3'($urandom), 3'($urandom), 3'($urandom),
                       8'($urandom), 8'($urandom), -1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_word, word;
        logic [7:0]  d;
        logic        prev_cs, prev_sclk, idle_seen;
        int          frames, low, inv, w;
        d = 8'($urandom);
        exp_word = model_frame(8'h01, 3'd3, 3'd6, 3'd1, d);
        req_cmd = 8'h01; req_tile_i = 3'd3; req_tile_j = 3'd6; req_op = 3'd1; req_data = d;
        req_valid = 1'b1;
        prev_cs = cs_n; prev_sclk = sclk; idle_seen = req_ready;
        frames = 0; low = 0; inv = 0; word = '0;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk); #1;
            if (busy === req_ready) inv++;
            if (!cs_n && prev_cs) begin
                frames++;
                low = 0;
                word = '0;
                n_checks++;
                if (idle_seen !== 1'b1) begin
                    n_fail++;
                    $display("FAIL b2b_gap: frame %0d started without an idle cycle", frames);
                end
                idle_seen = 1'b0;
            end
            if (cs_n && req_ready) idle_seen = 1'b1;
            if (!cs_n) low++;
            if (sclk && !prev_sclk) word = {word[30:0], mosi};
            if (cs_n && !prev_cs) begin
                n_checks++;
                if (low !== CS_LOW || word !== exp_word) begin
                    n_fail++;
                    $display("FAIL b2b_frame: low %0d word %h want %0d %h", low, word, CS_LOW,
                             exp_word);
                end
            end
            prev_cs = cs_n;
            prev_sclk = sclk;
        end
        req_valid = 1'b0;
        n_checks++;
        if (frames < 2 || inv !== 0) begin
            n_fail++;
            $display("FAIL b2b_summary: frames %0d ready/busy violations %0d want >=2 and 0",
                     frames, inv);
        end
        w = 0;
        while (busy && w < 2000) begin
            @(posedge clk); #1;
            w++;
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_drain: busy %b want 0", busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_frame();
        test_compute_done();
        test_compute_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
